riscv_decode_stage: RTL and testbench
=====================================

# riscv_decode_stage

Registered RV32I decode stage sitting between the fetch unit and issue in the mig-u core. It accepts one 32-bit instruction per cycle from fetch over a valid/ready handshake and splits it into register fields and a fully sign-extended immediate selected by instruction format. It flags illegal encodings and presents the decoded result downstream through a 2-entry skid buffer, so a full-rate stream sustains throughput under back-pressure. A flush input clears the stage, and a free-running counter tracks retired decodes.

## Interface
- ADDR_WIDTH, 32: byte-address width of the PC; the PC is carried as word address [ADDR_WIDTH-1:2].
- CNT_WIDTH, 32: width of the decoded-instruction counter.
- clk  in  1  core clock, rising edge.
- rst  in  1  reset, asynchronous and active-low.
- flush  in  1  discard all buffered instructions.
- fetch_valid  in  1  fetch presents an instruction.
- fetch_ready  out  1  stage can accept an instruction this cycle.
- fetch_pc  in  ADDR_WIDTH-2  word address of the instruction.
- fetch_insn  in  32  raw instruction.
- dec_valid  out  1  decoded instruction present.
- dec_ready  in  1  consumer takes the instruction.
- dec_pc  out  ADDR_WIDTH-2  word address of the decoded instruction.
- dec_opcode  out  7  insn[6:0].
- dec_rd, dec_rs1, dec_rs2  out  5 each  insn[11:7], insn[19:15], insn[24:20].
- dec_funct3  out  3  insn[14:12].
- dec_funct7  out  7  insn[31:25].
- dec_imm  out  32  format-selected, sign-extended immediate.
- dec_fmt  out  3  format code (insn_fmt_t).
- dec_illegal  out  1  unsupported or illegal encoding.
- dec_count  out  CNT_WIDTH  number of dec_valid && dec_ready transfers since reset.

## Operation
- Transfers:
  - An upstream transfer happens when fetch_valid && fetch_ready.
  - A downstream transfer happens when dec_valid && dec_ready.
- Decode is combinational on fetch_insn. The decoded bundle is written into the skid buffer on acceptance, so buffer contents are already decoded.
- Buffer states:
  - EMPTY (0 entries): fetch_ready=1, dec_valid=0.
  - ONE (1 entry): fetch_ready=1, dec_valid=1.
  - FULL (2 entries): fetch_ready=0, dec_valid=1.
- Buffer transitions:
  - Accept without take: EMPTY→ONE, ONE→FULL.
  - Take without accept: FULL→ONE, ONE→EMPTY.
  - Accept and take together: the state is unchanged, and order is preserved (FIFO).
- fetch_ready is a registered signal and never depends combinationally on dec_ready.
- Format by opcode:
  - U-type: 0110111, 0010111.
  - J-type: 1101111.
  - I-type: 1100111, 0000011, 0010011, 0001111, 1110011.
  - B-type: 1100011.
  - S-type: 0100011.
  - R-type: 0110011.
  - Anything else: FMT_ILL with dec_illegal=1.
  - insn[1:0]≠2'b11 also gives dec_illegal=1.
- Immediate construction:
  - I: sext(insn[31:20]).
  - S: sext({insn[31:25],insn[11:7]}).
  - B: sext({insn[31],insn[7],insn[30:25],insn[11:8],1'b0}).
  - U: {insn[31:12],12'b0}.
  - J: sext({insn[31],insn[19:12],insn[20],insn[30:21],1'b0}).
  - R and ILL: 0.
- Illegal instructions are passed downstream like any other instruction, with dec_illegal set; they are not dropped.
- dec_count increments by 1 on each downstream transfer and wraps modulo 2^CNT_WIDTH.
- Flush:
  - Next cycle, the buffer is EMPTY, dec_valid=0 and fetch_ready=1.
  - An instruction offered in the flush cycle is discarded.
  - A downstream transfer in the flush cycle still counts.

## Timing
- Latency from fetch acceptance to dec_valid is 1 cycle.
- Throughput is 1 instruction per cycle while dec_ready=1.
- Reset values: fetch_ready=1, dec_valid=0, dec_count=0, and all dec_* data outputs=0 (dec_fmt=FMT_R).
- Reset asserted mid-stream drops all entries asynchronously.
- dec_* data is stable while dec_valid && !dec_ready.
- dec_* data is don't-care-free: it holds its last value when dec_valid=0.
- Flush and reset take priority over any simultaneous accept.

## Structure
- Package riscv_pkg holds:
  - opcode localparams (OPC_LUI … OPC_SYSTEM);
  - the insn_fmt_t enum (FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_ILL);
  - the decoded-bundle struct decoded_insn_t.
- Sub-module riscv_imm_gen: combinational format decode and immediate generation (insn → fmt, imm, illegal).
- Top level contains the 2-entry skid buffer, flush logic and the counter.

## Test plan
- Basic decode: PC 0x400 (word 0x100), insn 0x00500093 (addi x1,x0,5), dec_ready=1 → next cycle dec_valid=1, dec_pc=0x100, rd=1, rs1=0, imm=0x00000005, fmt=FMT_I, illegal=0; then dec_count=1.
- Immediates: 0xFE000EE3 (beq x0,x0,-4) → imm=0xFFFFFFFC, fmt=FMT_B. 0x123450B7 (lui x1) → imm=0x12345000, fmt=FMT_U, rd=1.
- Illegal: 0x00000000 → dec_illegal=1, fmt=FMT_ILL, still delivered.
- Back-pressure: stream 4 instructions with dec_ready=0 → fetch_ready drops after 2 accepts. Then raise dec_ready → all 4 emerge in order with no loss or duplication; dec_count=4.
- Flush with buffer FULL: assert flush while fetch offers a 3rd instruction → next cycle dec_valid=0, fetch_ready=1; the flushed and offered instructions never appear.
- Reset: assert reset mid-stream → outputs return immediately to their reset values; dec_count=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions for the mig-u decode stage.
//   - OPC_*          : major opcode values, insn[6:0]
//   - insn_fmt_t     : instruction format code carried as dec_fmt
//   - decoded_insn_t : decoded bundle stored in the skid buffer (PC kept apart
//                      because its width is a parameter of the stage)
package riscv_pkg;

   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   // FMT_R is encoded as zero so an all-zero bundle is the reset value.
   typedef enum logic [2:0] {
      FMT_R   = 3'd0,
      FMT_I   = 3'd1,
      FMT_S   = 3'd2,
      FMT_B   = 3'd3,
      FMT_U   = 3'd4,
      FMT_J   = 3'd5,
      FMT_ILL = 3'd6
   } insn_fmt_t;

   typedef struct packed {
      logic [6:0]  opcode;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic [31:0] imm;
      insn_fmt_t   fmt;
      logic        illegal;
   } decoded_insn_t;

endpackage

// File: rtl/riscv_decode_stage_if.sv
// Fetch-side and issue-side handshake bundle of the decode stage.
//   master : the environment (fetch drives fetch_*, issue drives dec_ready)
//   slave  : the decode stage (drives fetch_ready and all dec_* results)
interface riscv_decode_stage_if
   import riscv_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int CNT_WIDTH  = 32
);
   logic                  fetch_valid;
   logic                  fetch_ready;
   logic [ADDR_WIDTH-1:2] fetch_pc;
   logic [31:0]           fetch_insn;

   logic                  dec_valid;
   logic                  dec_ready;
   logic [ADDR_WIDTH-1:2] dec_pc;
   logic [6:0]            dec_opcode;
   logic [4:0]            dec_rd;
   logic [4:0]            dec_rs1;
   logic [4:0]            dec_rs2;
   logic [2:0]            dec_funct3;
   logic [6:0]            dec_funct7;
   logic [31:0]           dec_imm;
   insn_fmt_t             dec_fmt;
   logic                  dec_illegal;
   logic [CNT_WIDTH-1:0]  dec_count;

   modport master (
      output fetch_valid, fetch_pc, fetch_insn, dec_ready,
      input  fetch_ready, dec_valid, dec_pc, dec_opcode, dec_rd, dec_rs1,
             dec_rs2, dec_funct3, dec_funct7, dec_imm, dec_fmt, dec_illegal,
             dec_count
   );

   modport slave (
      input  fetch_valid, fetch_pc, fetch_insn, dec_ready,
      output fetch_ready, dec_valid, dec_pc, dec_opcode, dec_rd, dec_rs1,
             dec_rs2, dec_funct3, dec_funct7, dec_imm, dec_fmt, dec_illegal,
             dec_count
   );
endinterface

// File: rtl/riscv_imm_gen.sv
// Combinational RV32I field split, format decode and immediate generation.
//   insn : raw 32-bit instruction
//   dec  : decoded bundle (fields, sign-extended immediate, format, illegal)
module riscv_imm_gen
   import riscv_pkg::*;
(
   input  logic [31:0]   insn,
   output decoded_insn_t dec
);
   insn_fmt_t   fmt;
   logic [31:0] imm;

   always_comb begin
      fmt = FMT_ILL;
      unique case (insn[6:0])
         OPC_LUI, OPC_AUIPC:                                     fmt = FMT_U;
         OPC_JAL:                                                fmt = FMT_J;
         OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_MISC_MEM, OPC_SYSTEM: fmt = FMT_I;
         OPC_BRANCH:                                             fmt = FMT_B;
         OPC_STORE:                                              fmt = FMT_S;
         OPC_OP:                                                 fmt = FMT_R;
         default:                                                fmt = FMT_ILL;
      endcase
   end

   always_comb begin
      imm = '0;
      unique case (fmt)
         FMT_I:   imm = {{20{insn[31]}}, insn[31:20]};
         FMT_S:   imm = {{20{insn[31]}}, insn[31:25], insn[11:7]};
         FMT_B:   imm = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
         FMT_U:   imm = {insn[31:12], 12'b0};
         FMT_J:   imm = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
         default: imm = '0;
      endcase
   end

   always_comb begin
      dec.opcode  = insn[6:0];
      dec.rd      = insn[11:7];
      dec.rs1     = insn[19:15];
      dec.rs2     = insn[24:20];
      dec.funct3  = insn[14:12];
      dec.funct7  = insn[31:25];
      dec.imm     = imm;
      dec.fmt     = fmt;
      // Every listed opcode already ends in 2'b11; the explicit term keeps
      // compressed/reserved encodings illegal should the table ever grow.
      dec.illegal = (fmt == FMT_ILL) || (insn[1:0] != 2'b11);
   end
endmodule

// File: rtl/riscv_decode_stage.sv
// Registered RV32I decode stage with a 2-entry skid buffer.
//   clk   : core clock, rising edge
//   rst   : asynchronous active-low reset
//   flush : empties the buffer next cycle, drops any same-cycle offer
//   bus   : fetch valid/ready input and decoded valid/ready output, plus
//           dec_count (downstream transfers since reset, wrapping)
// Entry 0 is always the head, so the dec_* outputs come straight from flops
// and keep their last value once the buffer drains.
module riscv_decode_stage
   import riscv_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int CNT_WIDTH  = 32
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   riscv_decode_stage_if.slave  bus
);
   typedef enum logic [1:0] {BUF_EMPTY, BUF_ONE, BUF_FULL} buf_state_t;

   buf_state_t            state_q, state_d;
   logic                  ready_q, ready_d;
   decoded_insn_t         ent0_q, ent0_d, ent1_q, ent1_d;
   logic [ADDR_WIDTH-1:2] pc0_q, pc0_d, pc1_q, pc1_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

   decoded_insn_t         new_dec;
   logic                  acc, take;

   riscv_imm_gen u_imm_gen (
      .insn (bus.fetch_insn),
      .dec  (new_dec)
   );

   assign acc  = bus.fetch_valid && ready_q;
   assign take = (state_q != BUF_EMPTY) && bus.dec_ready;

   always_comb begin
      state_d = state_q;
      ent0_d  = ent0_q;
      ent1_d  = ent1_q;
      pc0_d   = pc0_q;
      pc1_d   = pc1_q;
      cnt_d   = take ? cnt_q + CNT_WIDTH'(1) : cnt_q;

      if (flush) begin
         state_d = BUF_EMPTY;
      end else begin
         unique case (state_q)
            BUF_EMPTY: if (acc) begin
               ent0_d  = new_dec;
               pc0_d   = bus.fetch_pc;
               state_d = BUF_ONE;
            end
            BUF_ONE: begin
               if (acc && take) begin
                  ent0_d = new_dec;
                  pc0_d  = bus.fetch_pc;
               end else if (acc) begin
                  ent1_d  = new_dec;
                  pc1_d   = bus.fetch_pc;
                  state_d = BUF_FULL;
               end else if (take) begin
                  state_d = BUF_EMPTY;
               end
            end
            BUF_FULL: if (take) begin
               // ready_q is low here, so no accept can coincide with the shift.
               ent0_d  = ent1_q;
               pc0_d   = pc1_q;
               state_d = BUF_ONE;
            end
            default: state_d = BUF_EMPTY;
         endcase
      end

      // Registered from the next state so it never sees dec_ready combinationally.
      ready_d = (state_d != BUF_FULL);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= BUF_EMPTY;
         ready_q <= 1'b1;
         ent0_q  <= '0;
         ent1_q  <= '0;
         pc0_q   <= '0;
         pc1_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ready_q <= ready_d;
         ent0_q  <= ent0_d;
         ent1_q  <= ent1_d;
         pc0_q   <= pc0_d;
         pc1_q   <= pc1_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.fetch_ready = ready_q;
   assign bus.dec_valid   = (state_q != BUF_EMPTY);
   assign bus.dec_pc      = pc0_q;
   assign bus.dec_opcode  = ent0_q.opcode;
   assign bus.dec_rd      = ent0_q.rd;
   assign bus.dec_rs1     = ent0_q.rs1;
   assign bus.dec_rs2     = ent0_q.rs2;
   assign bus.dec_funct3  = ent0_q.funct3;
   assign bus.dec_funct7  = ent0_q.funct7;
   assign bus.dec_imm     = ent0_q.imm;
   assign bus.dec_fmt     = ent0_q.fmt;
   assign bus.dec_illegal = ent0_q.illegal;
   assign bus.dec_count   = cnt_q;
endmodule

// File: tb/tb_riscv_decode_stage.sv
module tb_riscv_decode_stage;
   import riscv_pkg::*;

   logic clk = 1'b0;
   logic rst;
   logic flush;
   int   n_chk = 0;
   int   n_err = 0;

   riscv_decode_stage_if #(.ADDR_WIDTH(32), .CNT_WIDTH(32)) bus ();

   riscv_decode_stage #(.ADDR_WIDTH(32), .CNT_WIDTH(32)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one instruction for one cycle (caller knows fetch_ready is high).
   task automatic send(input logic [29:0] pc, input logic [31:0] insn);
      bus.fetch_valid = 1'b1;
      bus.fetch_pc    = pc;
      bus.fetch_insn  = insn;
      step();
      bus.fetch_valid = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_rdy"},  64'(bus.fetch_ready), 64'd1);
      chk({tag, "_vld"},  64'(bus.dec_valid),   64'd0);
      chk({tag, "_cnt"},  64'(bus.dec_count),   64'd0);
      chk({tag, "_pc"},   64'(bus.dec_pc),      64'd0);
      chk({tag, "_imm"},  64'(bus.dec_imm),     64'd0);
      chk({tag, "_fmt"},  64'(bus.dec_fmt),     64'(FMT_R));
      chk({tag, "_ill"},  64'(bus.dec_illegal), 64'd0);
   endtask

   // addi x1,x0,k: tags back-pressure stream entries through their immediate
   function automatic logic [31:0] addi_k(input int k);
      return {12'(k), 5'd0, 3'd0, 5'd1, 7'h13};
   endfunction

   initial begin
      rst             = 1'b0;
      flush           = 1'b0;
      bus.fetch_valid = 1'b0;
      bus.fetch_pc    = '0;
      bus.fetch_insn  = '0;
      bus.dec_ready   = 1'b0;
      #12;
      chk_reset_vals("rst");
      rst = 1'b1;
      step();

      // Basic decode: addi x1,x0,5 at word 0x100
      bus.dec_ready = 1'b1;
      send(30'h100, 32'h00500093);
      chk("basic_vld", 64'(bus.dec_valid),   64'd1);
      chk("basic_pc",  64'(bus.dec_pc),      64'h100);
      chk("basic_opc", 64'(bus.dec_opcode),  64'h13);
      chk("basic_rd",  64'(bus.dec_rd),      64'd1);
      chk("basic_rs1", 64'(bus.dec_rs1),     64'd0);
      chk("basic_imm", 64'(bus.dec_imm),     64'h5);
      chk("basic_fmt", 64'(bus.dec_fmt),     64'(FMT_I));
      chk("basic_ill", 64'(bus.dec_illegal), 64'd0);
      step();
      chk("basic_cnt",  64'(bus.dec_count), 64'd1);
      chk("basic_idle", 64'(bus.dec_valid), 64'd0);
      chk("basic_hold", 64'(bus.dec_imm),   64'h5);

      // beq x0,x0,-4
      send(30'h101, 32'hFE000EE3);
      chk("beq_imm", 64'(bus.dec_imm), 64'hFFFFFFFC);
      chk("beq_fmt", 64'(bus.dec_fmt), 64'(FMT_B));
      // lui x1,0x12345 (back to back with the beq)
      send(30'h102, 32'h123450B7);
      chk("lui_imm", 64'(bus.dec_imm), 64'h12345000);
      chk("lui_fmt", 64'(bus.dec_fmt), 64'(FMT_U));
      chk("lui_rd",  64'(bus.dec_rd),  64'd1);
      // sw x1,-8(x2)
      send(30'h103, 32'hFE112C23);
      chk("sw_imm", 64'(bus.dec_imm), 64'hFFFFFFF8);
      chk("sw_fmt", 64'(bus.dec_fmt), 64'(FMT_S));
      chk("sw_rs2", 64'(bus.dec_rs2), 64'd1);
      // jal x0,-4
      send(30'h104, 32'hFFDFF06F);
      chk("jal_imm", 64'(bus.dec_imm), 64'hFFFFFFFC);
      chk("jal_fmt", 64'(bus.dec_fmt), 64'(FMT_J));
      // add x3,x1,x2
      send(30'h105, 32'h002081B3);
      chk("add_imm", 64'(bus.dec_imm), 64'd0);
      chk("add_fmt", 64'(bus.dec_fmt), 64'(FMT_R));
      chk("add_rd",  64'(bus.dec_rd),  64'd3);
      chk("add_f7",  64'(bus.dec_funct7), 64'd0);
      // all-zero word: illegal but still delivered
      send(30'h106, 32'h00000000);
      chk("ill_vld", 64'(bus.dec_valid),   64'd1);
      chk("ill_ill", 64'(bus.dec_illegal), 64'd1);
      chk("ill_fmt", 64'(bus.dec_fmt),     64'(FMT_ILL));
      chk("ill_imm", 64'(bus.dec_imm),     64'd0);
      // low bits != 2'b11
      send(30'h107, 32'h00500090);
      chk("c16_ill", 64'(bus.dec_illegal), 64'd1);
      chk("c16_pc",  64'(bus.dec_pc),      64'h107);
      step();
      chk("dir_cnt", 64'(bus.dec_count), 64'd8);

      // Back-pressure: 4 instructions, consumer stalled for the first 4 cycles
      begin
         int sent = 0;
         int recvd = 0;
         logic acc;
         bus.dec_ready = 1'b0;
         for (int cyc = 0; cyc < 40 && recvd < 4; cyc++) begin
            bus.fetch_valid = (sent < 4);
            bus.fetch_pc    = 30'(32'h200 + sent);
            bus.fetch_insn  = addi_k(sent);
            bus.dec_ready   = (cyc >= 4);
            if (cyc == 3) begin
               chk("bp_rdy_low", 64'(bus.fetch_ready), 64'd0);
               chk("bp_sent2",   64'(sent),            64'd2);
               chk("bp_stable",  64'(bus.dec_imm),     64'd0);
            end
            acc = bus.fetch_valid && bus.fetch_ready;
            if (bus.dec_valid && bus.dec_ready) begin
               chk("bp_imm", 64'(bus.dec_imm), 64'(recvd));
               chk("bp_pc",  64'(bus.dec_pc),  64'(32'h200 + recvd));
               recvd++;
            end
            step();
            if (acc) sent++;
         end
         bus.fetch_valid = 1'b0;
         chk("bp_recvd", 64'(recvd), 64'd4);
         chk("bp_empty", 64'(bus.dec_valid), 64'd0);
         // 8 earlier transfers plus these 4
         chk("bp_cnt", 64'(bus.dec_count), 64'd12);
      end

      // Flush with the buffer FULL while a third instruction is offered
      bus.dec_ready = 1'b0;
      send(30'h300, addi_k(100));
      send(30'h301, addi_k(101));
      chk("fl_full", 64'(bus.fetch_ready), 64'd0);
      flush = 1'b1;
      bus.fetch_valid = 1'b1;
      bus.fetch_pc    = 30'h302;
      bus.fetch_insn  = addi_k(102);
      step();
      flush = 1'b0;
      bus.fetch_valid = 1'b0;
      chk("fl_vld", 64'(bus.dec_valid),   64'd0);
      chk("fl_rdy", 64'(bus.fetch_ready), 64'd1);
      bus.dec_ready = 1'b1;
      step();
      step();
      chk("fl_gone", 64'(bus.dec_valid), 64'd0);
      chk("fl_cnt",  64'(bus.dec_count), 64'd12);

      // A take in the flush cycle still counts
      bus.dec_ready = 1'b0;
      send(30'h310, addi_k(7));
      bus.dec_ready = 1'b1;
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flt_cnt", 64'(bus.dec_count), 64'd13);
      chk("flt_vld", 64'(bus.dec_valid), 64'd0);

      // Reset mid-stream: outputs go back to reset values without a clock edge
      bus.dec_ready = 1'b0;
      send(30'h320, 32'h123450B7);
      send(30'h321, 32'hFE000EE3);
      #2;
      rst = 1'b0;
      #1;
      chk_reset_vals("arst");
      bus.fetch_valid = 1'b1;
      step();
      chk("arst_hold", 64'(bus.dec_valid), 64'd0);
      bus.fetch_valid = 1'b0;
      rst = 1'b1;
      step();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: sim still running at %0t, want finished", $time);
      $fatal(1);
   end
endmodule
